// File: rtl/crypt_pkg.sv
// Shared types and constants for the crypt scheduler and its round-robin arbiter.
package crypt_pkg;
    localparam int   BLK_W    = 128;
    localparam int   KEY_W    = 10;
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;
endpackage

// File: rtl/crypt_rr_arb.sv
// Two-way round-robin grant: on a tie the port other than the last winner (rr) is granted.
module crypt_rr_arb (
    input  logic valid0,
    input  logic valid1,
    input  logic rr,
    output logic grant_valid,
    output logic grant_id
);
    always_comb begin
        grant_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            grant_id = ~rr;
        end else begin
            grant_id = valid1;
        end
    end
endmodule

// File: rtl/crypt_sched.sv
// Shares one combinational encrypt/decrypt core between two requesters with a LAT-cycle settle window.
// Optional per-requester completion counters cnt0/cnt1 exist only when CRYPT_SCHED_PERF_EN is defined.
module crypt_sched
    import crypt_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_mode,
    input  logic [KEY_W-1:0] req0_key,
    input  logic [BLK_W-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_mode,
    input  logic [KEY_W-1:0] req1_key,
    input  logic [BLK_W-1:0] req1_data,
    output logic             core_mode,
    output logic [KEY_W-1:0] core_key,
    output logic [BLK_W-1:0] core_data,
    input  logic [BLK_W-1:0] core_enc,
    input  logic [BLK_W-1:0] core_dec,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [BLK_W-1:0] resp_data
`ifdef CRYPT_SCHED_PERF_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);
    localparam logic [3:0] SETTLE_INIT = 4'(LAT - 1);

    state_t     state_reg;
    state_t     state_next;
    logic       rr_reg;
    logic       id_reg;
    logic [3:0] settle_reg;
    logic       grant_valid;
    logic       grant_id;
    logic       accept;
    logic       capture;
    logic       handshake;

    crypt_rr_arb u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .rr          (rr_reg),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;
        case (state_reg)
            IDLE: begin
                req0_ready = grant_valid && !grant_id;
                req1_ready = grant_valid && grant_id;
                if (grant_valid) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (settle_reg == 4'd0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // core_* are loaded only on accept so the core inputs stay frozen through the settle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_reg     <= 1'b1;
            id_reg     <= 1'b0;
            settle_reg <= 4'd0;
            core_mode  <= MODE_ENC;
            core_key   <= '0;
            core_data  <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
        end else begin
            if (accept) begin
                rr_reg     <= grant_id;
                id_reg     <= grant_id;
                settle_reg <= SETTLE_INIT;
                core_mode  <= grant_id ? req1_mode : req0_mode;
                core_key   <= grant_id ? req1_key  : req0_key;
                core_data  <= grant_id ? req1_data : req0_data;
            end else if (state_reg == WAIT && settle_reg != 4'd0) begin
                settle_reg <= settle_reg - 4'd1;
            end

            if (capture) begin
                resp_valid <= 1'b1;
                resp_id    <= id_reg;
                resp_data  <= (core_mode == MODE_DEC) ? core_dec : core_enc;
            end else if (handshake) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef CRYPT_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (handshake) begin
            if (resp_id) begin
                cnt1 <= cnt1 + 1'b1;
            end else begin
                cnt0 <= cnt0 + 1'b1;
            end
        end
    end
`else
    // CNT_W only sizes the optional counters; referenced here so the default build stays lint-clean.
    if (CNT_W > 0) begin : g_cnt_w_unused
    end
`endif
endmodule

// File: tb/tb_crypt_sched.sv
// Self-checking bench for crypt_sched: scoreboard of expected responses, one task per scenario.
module tb_crypt_sched;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic         id;
        logic [127:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_n;
    logic         req0_valid, req1_valid, req0_mode, req1_mode, resp_ready;
    logic         req0_ready, req1_ready;
    logic [9:0]   req0_key, req1_key;
    logic [127:0] req0_data, req1_data;
    logic         core_mode, resp_valid, resp_id;
    logic [9:0]   core_key;
    logic [127:0] core_data, core_enc, core_dec, resp_data;
    logic [CNT_W-1:0] cnt0, cnt1;

    // Second instance with LAT=3 and a bench-driven core for capture-timing checks.
    logic         d3_valid, d3_ready, d3_req1_ready, d3_mode, d3_resp_ready;
    logic         d3_zero_bit;
    logic [9:0]   d3_key, d3_zero_key;
    logic [127:0] d3_data, d3_zero_data, d3_enc, d3_dec;
    logic         d3_core_mode, d3_resp_valid, d3_resp_id;
    logic [9:0]   d3_core_key;
    logic [127:0] d3_core_data, d3_resp_data;
    logic [CNT_W-1:0] d3_cnt0, d3_cnt1;

    int   checks   = 0;
    int   failures = 0;
    logic rr_m     = 1'b1;
    exp_t sb[$];

    function automatic logic [127:0] f_enc(input logic [9:0] k, input logic [127:0] d);
        return d ^ {{12{k}}, 8'h5A};
    endfunction

    function automatic logic [127:0] f_dec(input logic [9:0] k, input logic [127:0] d);
        return ~d ^ {8'hA5, {12{k}}};
    endfunction

    assign core_enc = f_enc(core_key, core_data);
    assign core_dec = f_dec(core_key, core_data);

    crypt_sched #(.LAT(2), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_key(req0_key), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_key(req1_key), .req1_data(req1_data),
        .core_mode(core_mode), .core_key(core_key), .core_data(core_data),
        .core_enc(core_enc), .core_dec(core_dec),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data)
`ifdef CRYPT_SCHED_PERF_EN
        , .cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    crypt_sched #(.LAT(3), .CNT_W(CNT_W)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d3_valid), .req0_ready(d3_ready), .req0_mode(d3_mode),
        .req0_key(d3_key), .req0_data(d3_data),
        .req1_valid(d3_zero_bit), .req1_ready(d3_req1_ready), .req1_mode(d3_zero_bit),
        .req1_key(d3_zero_key), .req1_data(d3_zero_data),
        .core_mode(d3_core_mode), .core_key(d3_core_key), .core_data(d3_core_data),
        .core_enc(d3_enc), .core_dec(d3_dec),
        .resp_valid(d3_resp_valid), .resp_ready(d3_resp_ready), .resp_id(d3_resp_id),
        .resp_data(d3_resp_data)
`ifdef CRYPT_SCHED_PERF_EN
        , .cnt0(d3_cnt0), .cnt1(d3_cnt1)
`endif
    );

`ifndef CRYPT_SCHED_PERF_EN
    assign cnt0 = '0;
    assign cnt1 = '0;
    assign d3_cnt0 = '0;
    assign d3_cnt1 = '0;
`endif

    task automatic wait_resp(output int lat);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        rr_m = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_id !== 1'b0) begin failures++; $display("FAIL reset_resp_id got=%b exp=0", resp_id); end
        checks++; if (resp_data !== 128'h0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
        checks++; if (core_mode !== 1'b0) begin failures++; $display("FAIL reset_core_mode got=%b exp=0", core_mode); end
        checks++; if (core_key !== 10'h0) begin failures++; $display("FAIL reset_core_key got=%h exp=0", core_key); end
        checks++; if (core_data !== 128'h0) begin failures++; $display("FAIL reset_core_data got=%h exp=0", core_data); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
        checks++; if (d3_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_d3_resp_valid got=%b exp=0", d3_resp_valid); end
`ifdef CRYPT_SCHED_PERF_EN
        checks++; if (cnt0 !== '0 || cnt1 !== '0) begin failures++; $display("FAIL reset_cnt got=%h/%h exp=0/0", cnt0, cnt1); end
`endif
        rst_n = 1'b1;
        rr_m = 1'b1;
        sb.delete();
        $display("reset: done");
    endtask

    task automatic test_single();
        int   lat;
        exp_t e;
        @(negedge clk);
        resp_ready = 1'b1;
        req0_mode  = 1'b0;
        req0_key   = 10'h2A5;
        req0_data  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        req0_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL single_ready got=%b%b exp=10", req0_ready, req1_ready); end
        sb.push_back('{id: 1'b0, data: f_enc(10'h2A5, 128'h00112233_44556677_8899AABB_CCDDEEFF)});
        rr_m = 1'b0;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req0_data  = '1;
        checks++; if (core_key !== 10'h2A5) begin failures++; $display("FAIL single_core_key got=%h exp=2a5", core_key); end
        checks++; if (core_data !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin failures++; $display("FAIL single_core_data got=%h", core_data); end
        wait_resp(lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", lat); end
        if (sb.size() == 0) begin
            checks++; failures++; $display("FAIL single_sb_empty got=0 entries exp=1");
        end else begin
            e = sb.pop_front();
            checks++; if (resp_id !== e.id) begin failures++; $display("FAIL single_resp_id got=%b exp=%b", resp_id, e.id); end
            checks++; if (resp_data !== e.data) begin failures++; $display("FAIL single_resp_data got=%h exp=%h", resp_data, e.data); end
        end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_resp_drop got=%b exp=0", resp_valid); end
        $display("single: id=%b data=%h latency=%0d", resp_id, resp_data, lat);
    endtask

    task automatic test_back_to_back();
        int   lat;
        int   last_cyc;
        bit   ok;
        logic g;
        exp_t e;
        do_reset();
        resp_ready = 1'b1;
        req0_mode = 1'b0; req0_key = 10'h155; req0_data = {$urandom, $urandom, $urandom, $urandom};
        req1_mode = 1'b1; req1_key = 10'h0F3; req1_data = {$urandom, $urandom, $urandom, $urandom};
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        last_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ready(ok);
            checks++; if (!ok) begin failures++; $display("FAIL b2b_ready_timeout txn=%0d got=no ready exp=ready", k); end
            g = ~rr_m;
            checks++; if (req0_ready !== ~g || req1_ready !== g) begin failures++; $display("FAIL b2b_grant txn=%0d got=%b%b exp_id=%b", k, req0_ready, req1_ready, g); end
            if (k > 0) begin
                checks++; if (cyc - last_cyc != 4) begin failures++; $display("FAIL b2b_interval txn=%0d got=%0d exp=4", k, cyc - last_cyc); end
            end
            last_cyc = cyc;
            if (g) sb.push_back('{id: 1'b1, data: f_dec(req1_key, req1_data)});
            else   sb.push_back('{id: 1'b0, data: f_enc(req0_key, req0_data)});
            rr_m = g;
            @(posedge clk);
            #1;
            if (g) req1_data = {$urandom, $urandom, $urandom, $urandom};
            else   req0_data = {$urandom, $urandom, $urandom, $urandom};
            wait_resp(lat);
            checks++; if (lat != 2) begin failures++; $display("FAIL b2b_latency txn=%0d got=%0d exp=2", k, lat); end
            checks++; if (resp_id !== 1'(k % 2)) begin failures++; $display("FAIL b2b_id_seq txn=%0d got=%b exp=%0d", k, resp_id, k % 2); end
            if (sb.size() == 0) begin
                checks++; failures++; $display("FAIL b2b_sb_empty txn=%0d got=0 entries exp=1", k);
            end else begin
                e = sb.pop_front();
                checks++; if (resp_data !== e.data) begin failures++; $display("FAIL b2b_resp_data txn=%0d got=%h exp=%h", k, resp_data, e.data); end
            end
            $display("back_to_back: txn=%0d id=%b data=%h", k, resp_id, resp_data);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t e;
        @(negedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        req1_mode = 1'b1; req1_key = 10'h3C1; req1_data = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        req1_valid = 1'b1;
        #1;
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b%b exp=01", req0_ready, req1_ready); end
        sb.push_back('{id: 1'b1, data: f_dec(10'h3C1, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D)});
        rr_m = 1'b1;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        req0_mode = 1'b0; req0_key = 10'h011; req0_data = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        req0_valid = 1'b1;
        wait_resp(lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL bp_latency got=%0d exp=2", lat); end
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, resp_valid); end
            checks++; if (resp_id !== e.id) begin failures++; $display("FAIL bp_hold_id cyc=%0d got=%b exp=%b", i, resp_id, e.id); end
            checks++; if (resp_data !== e.data) begin failures++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=%h", i, resp_data, e.data); end
            checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready cyc=%0d got=%b%b exp=00", i, req0_ready, req1_ready); end
            checks++; if (core_mode !== 1'b1 || core_key !== 10'h3C1) begin failures++; $display("FAIL bp_core_hold cyc=%0d got=%b/%h exp=1/3c1", i, core_mode, core_key); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL bp_taken got=%b exp=0", resp_valid); end
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL bp_next_grant got=%b%b exp=10", req0_ready, req1_ready); end
        sb.push_back('{id: 1'b0, data: f_enc(10'h011, 128'h0F0E0D0C_0B0A0908_07060504_03020100)});
        rr_m = 1'b0;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_resp(lat);
        if (sb.size() == 0) begin
            checks++; failures++; $display("FAIL bp_sb_empty got=0 entries exp=1");
        end else begin
            e = sb.pop_front();
            checks++; if (resp_id !== e.id || resp_data !== e.data) begin failures++; $display("FAIL bp_followup got=%b/%h exp=%b/%h", resp_id, resp_data, e.id, e.data); end
        end
        $display("backpressure: id=%b data=%h", resp_id, resp_data);
        @(negedge clk);
    endtask

    task automatic test_capture_lat3();
        @(negedge clk);
        d3_resp_ready = 1'b0;
        d3_enc = 128'hA; d3_dec = 128'h1A;
        d3_mode = 1'b0; d3_key = 10'h1E7; d3_data = 128'h55;
        d3_valid = 1'b1;
        #1;
        checks++; if (d3_ready !== 1'b1) begin failures++; $display("FAIL lat3_ready got=%b exp=1", d3_ready); end
        @(posedge clk);
        #1; d3_valid = 1'b0; d3_data = 128'h77; d3_enc = 128'hB;
        @(negedge clk);
        checks++; if (d3_resp_valid !== 1'b0) begin failures++; $display("FAIL lat3_early1 got=%b exp=0", d3_resp_valid); end
        @(posedge clk);
        #1; d3_enc = 128'hC;
        @(negedge clk);
        checks++; if (d3_core_key !== 10'h1E7 || d3_core_data !== 128'h55) begin failures++; $display("FAIL lat3_core_wait got=%h/%h exp=1e7/55", d3_core_key, d3_core_data); end
        @(posedge clk);
        #1; d3_enc = 128'hD;
        @(negedge clk);
        checks++; if (d3_resp_valid !== 1'b0) begin failures++; $display("FAIL lat3_early3 got=%b exp=0", d3_resp_valid); end
        @(posedge clk);
        #1; d3_enc = 128'hE;
        @(negedge clk);
        checks++; if (d3_resp_valid !== 1'b1) begin failures++; $display("FAIL lat3_valid got=%b exp=1", d3_resp_valid); end
        checks++; if (d3_resp_data !== 128'hD) begin failures++; $display("FAIL lat3_capture got=%h exp=d", d3_resp_data); end
        checks++; if (d3_resp_id !== 1'b0) begin failures++; $display("FAIL lat3_id got=%b exp=0", d3_resp_id); end
        @(negedge clk);
        checks++; if (d3_resp_data !== 128'hD || d3_core_mode !== 1'b0 || d3_core_data !== 128'h55) begin failures++; $display("FAIL lat3_done_hold got=%h/%b/%h exp=d/0/55", d3_resp_data, d3_core_mode, d3_core_data); end
        checks++; if (d3_ready !== 1'b0 || d3_req1_ready !== 1'b0) begin failures++; $display("FAIL lat3_done_ready got=%b%b exp=00", d3_ready, d3_req1_ready); end
        d3_resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (d3_resp_valid !== 1'b0) begin failures++; $display("FAIL lat3_taken got=%b exp=0", d3_resp_valid); end
        $display("capture_lat3: data=%h", d3_resp_data);
    endtask

    task automatic test_reset_mid();
        int   lat;
        int   seen;
        exp_t e;
        @(negedge clk);
        resp_ready = 1'b1;
        req0_mode = 1'b1; req0_key = 10'h3FF; req0_data = 128'h1234;
        req0_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", req0_ready); end
        sb.push_back('{id: 1'b0, data: f_dec(10'h3FF, 128'h1234)});
        @(posedge clk);
        #1; req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        rr_m = 1'b1;
        checks++; if (core_key !== 10'h0 || core_data !== 128'h0 || core_mode !== 1'b0) begin failures++; $display("FAIL rstmid_core got=%b/%h/%h exp=0/0/0", core_mode, core_key, core_data); end
        checks++; if (resp_valid !== 1'b0 || resp_data !== 128'h0) begin failures++; $display("FAIL rstmid_resp got=%b/%h exp=0/0", resp_valid, resp_data); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_no_resp got=%0d cycles valid exp=0", seen); end
        req0_mode = 1'b0; req0_key = 10'h0AA; req0_data = 128'h99;
        req1_mode = 1'b0; req1_key = 10'h055; req1_data = 128'h66;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL rstmid_tie got=%b%b exp=10", req0_ready, req1_ready); end
        sb.push_back('{id: 1'b0, data: f_enc(10'h0AA, 128'h99)});
        rr_m = 1'b0;
        @(posedge clk);
        #1; req0_valid = 1'b0; req1_valid = 1'b0;
        wait_resp(lat);
        if (sb.size() == 0) begin
            checks++; failures++; $display("FAIL rstmid_sb_empty got=0 entries exp=1");
        end else begin
            e = sb.pop_front();
            checks++; if (resp_id !== e.id || resp_data !== e.data) begin failures++; $display("FAIL rstmid_resp_after got=%b/%h exp=%b/%h", resp_id, resp_data, e.id, e.data); end
        end
        $display("reset_mid: id=%b data=%h", resp_id, resp_data);
        @(negedge clk);
    endtask

`ifdef CRYPT_SCHED_PERF_EN
    task automatic test_perf();
        int lat;
        bit ok;
        do_reset();
        resp_ready = 1'b1;
        req1_mode = 1'b0; req1_key = 10'h101; req1_data = 128'h42;
        for (int k = 0; k < 17; k++) begin
            req1_valid = 1'b1;
            wait_ready(ok);
            @(posedge clk);
            #1; req1_valid = 1'b0;
            wait_resp(lat);
            @(negedge clk);
            if (k == 14) begin
                checks++; if (cnt1 !== 4'd15) begin failures++; $display("FAIL perf_cnt1_15 got=%0d exp=15", cnt1); end
            end
        end
        checks++; if (cnt1 !== 4'd1) begin failures++; $display("FAIL perf_cnt1_wrap got=%0d exp=1", cnt1); end
        checks++; if (cnt0 !== 4'd0) begin failures++; $display("FAIL perf_cnt0 got=%0d exp=0", cnt0); end
        $display("perf: cnt0=%0d cnt1=%0d", cnt0, cnt1);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_mode = 1'b0; req1_mode = 1'b0;
        req0_key = '0; req1_key = '0; req0_data = '0; req1_data = '0;
        resp_ready = 1'b1;
        d3_valid = 1'b0; d3_mode = 1'b0; d3_key = '0; d3_data = '0; d3_resp_ready = 1'b1;
        d3_zero_bit = 1'b0; d3_zero_key = '0; d3_zero_data = '0;
        d3_enc = '0; d3_dec = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_capture_lat3();
        test_reset_mid();
`ifdef CRYPT_SCHED_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end
endmodule
